// File: rtl/mixer_freq_sched.sv
// Round-robin scheduler that time-shares one IQ mixer/DDS among NCH channels.
// Each slot retunes the mixer, blanks its output while the pipeline settles, then tags it valid.
module mixer_freq_sched #(
  parameter int NCH    = 4,
  parameter int DWELL  = 64,
  parameter int SETTLE = 8,
  localparam int CHW   = $clog2(NCH),
  localparam int CNTW  = $clog2(DWELL)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_stb,
  input  logic [CHW-1:0]  wr_ch,
  input  logic [1:0]      wr_sel,
  input  logic [15:0]     wr_data,
  input  logic            run,
  output logic [47:0]     phase_inc,
  output logic [CHW-1:0]  ch_out,
  output logic            ch_valid,
  output logic [NCH-1:0]  pend,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETTLE, S_ACTIVE} state_t;

  localparam logic [CNTW-1:0] SETTLE_END = CNTW'(SETTLE);
  localparam logic [CNTW-1:0] SLOT_END   = CNTW'(DWELL - 1);
  localparam logic [CHW-1:0]  LAST_CH    = CHW'(NCH - 1);

  state_t          state, state_next;
  logic [CNTW-1:0] cnt, cnt_next;
  logic [CHW-1:0]  slot_ch;
  logic            advance;

  logic [15:0] stage_low, stage_mid;
  logic [47:0] pending [NCH];
  logic [47:0] active  [NCH];

  // cnt runs 0..DWELL-1 across a slot: LOAD at 0, SETTLE at 1..SETTLE, ACTIVE after that
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    advance    = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) begin
          state_next = S_LOAD;
          cnt_next   = '0;
        end
      end
      S_LOAD: begin
        state_next = S_SETTLE;
        cnt_next   = cnt + 1'b1;
      end
      S_SETTLE: begin
        cnt_next = cnt + 1'b1;
        if (cnt == SETTLE_END) state_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (cnt == SLOT_END) begin
          cnt_next   = '0;
          advance    = 1'b1;
          state_next = run ? S_LOAD : S_IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      slot_ch  <= '0;
      ch_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      ch_valid <= (state_next == S_ACTIVE);
      busy     <= (state_next != S_IDLE);
      if (advance) slot_ch <= (slot_ch == LAST_CH) ? '0 : slot_ch + 1'b1;
    end
  end

  // A commit landing on the same edge as LOAD wins the pend bit, so it survives to the next visit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_low <= '0;
      stage_mid <= '0;
      pend      <= '0;
      phase_inc <= '0;
      ch_out    <= '0;
      for (int i = 0; i < NCH; i++) begin
        pending[i] <= '0;
        active[i]  <= '0;
      end
    end else begin
      if (state == S_LOAD) begin
        ch_out <= slot_ch;
        if (pend[slot_ch]) begin
          active[slot_ch] <= pending[slot_ch];
          phase_inc       <= pending[slot_ch];
          pend[slot_ch]   <= 1'b0;
        end else begin
          phase_inc <= active[slot_ch];
        end
      end
      if (wr_stb) begin
        case (wr_sel)
          2'd0: stage_low <= wr_data;
          2'd1: stage_mid <= wr_data;
          2'd2: begin
            pending[wr_ch] <= {wr_data, stage_mid, stage_low};
            pend[wr_ch]    <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mixer_freq_sched.sv
// Directed bench for mixer_freq_sched: slot timing, retune/commit ordering, run stop/restart, async reset.
module tb_mixer_freq_sched;

  localparam int NCH    = 4;
  localparam int DWELL  = 64;
  localparam int SETTLE = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_stb = 1'b0;
  logic [1:0]  wr_ch = '0;
  logic [1:0]  wr_sel = '0;
  logic [15:0] wr_data = '0;
  logic        run = 1'b0;
  logic [47:0] phase_inc;
  logic [1:0]  ch_out;
  logic        ch_valid;
  logic [3:0]  pend;
  logic        busy;

  mixer_freq_sched #(.NCH(NCH), .DWELL(DWELL), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .wr_stb(wr_stb), .wr_ch(wr_ch), .wr_sel(wr_sel),
    .wr_data(wr_data), .run(run), .phase_inc(phase_inc), .ch_out(ch_out),
    .ch_valid(ch_valid), .pend(pend), .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle index; read at negedge it names the cycle that began at the last posedge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec_count  = 0;
  int miss_count = 0;

  logic [47:0] v0  = 48'h000A_000B_000C;
  logic [47:0] v1o = 48'h0001_0002_0003;
  logic [47:0] v1n = 48'h0004_0005_0006;
  logic [47:0] v2  = 48'h3333_2222_1111;
  logic [47:0] v3  = 48'h0007_0008_0009;

  int t0, t1, t2;

  task automatic checkOutput(input string tag, input logic [47:0] got, input logic [47:0] exp);
    vec_count++;
    if (got !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] ch, input logic [1:0] sel, input logic [15:0] data);
    wr_stb  = 1'b1;
    wr_ch   = ch;
    wr_sel  = sel;
    wr_data = data;
    @(negedge clk);
    wr_stb  = 1'b0;
  endtask

  task automatic writeInc(input logic [1:0] ch, input logic [47:0] v);
    applyStimulus(ch, 2'd0, v[15:0]);
    applyStimulus(ch, 2'd1, v[31:16]);
    applyStimulus(ch, 2'd2, v[47:32]);
  endtask

  task automatic gotoCycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_phase", phase_inc, 48'h0);
    checkOutput("rst_ch_out", {46'h0, ch_out}, 48'h0);
    checkOutput("rst_valid", {47'h0, ch_valid}, 48'h0);
    checkOutput("rst_pend", {44'h0, pend}, 48'h0);
    checkOutput("rst_busy", {47'h0, busy}, 48'h0);
    reset = 1'b0;
    @(negedge clk);

    writeInc(2'd2, v2);
    checkOutput("wr_pend_ch2", {44'h0, pend}, 48'h4);
    checkOutput("wr_phase_idle", phase_inc, 48'h0);
    checkOutput("wr_busy_idle", {47'h0, busy}, 48'h0);
    writeInc(2'd1, v1o);
    writeInc(2'd3, v3);
    checkOutput("wr_pend_all", {44'h0, pend}, 48'hE);

    run = 1'b1;
    t0 = cyc + 1;
    gotoCycle(t0);
    checkOutput("load0_busy", {47'h0, busy}, 48'h1);
    checkOutput("load0_valid", {47'h0, ch_valid}, 48'h0);
    gotoCycle(t0 + 1);
    checkOutput("slot0_ch", {46'h0, ch_out}, 48'h0);
    checkOutput("slot0_phase", phase_inc, 48'h0);
    gotoCycle(t0 + 8);
    checkOutput("settle_last_valid", {47'h0, ch_valid}, 48'h0);
    gotoCycle(t0 + 9);
    checkOutput("valid_rise", {47'h0, ch_valid}, 48'h1);
    checkOutput("valid_rise_ch", {46'h0, ch_out}, 48'h0);

    gotoCycle(t0 + 20);
    applyStimulus(2'd0, 2'd0, v1n[15:0]);
    applyStimulus(2'd0, 2'd1, v1n[31:16]);
    gotoCycle(t0 + 63);
    checkOutput("active_last_valid", {47'h0, ch_valid}, 48'h1);
    gotoCycle(t0 + 64);
    checkOutput("load1_valid", {47'h0, ch_valid}, 48'h0);
    applyStimulus(2'd1, 2'd2, v1n[47:32]);
    checkOutput("slot1_ch", {46'h0, ch_out}, 48'h1);
    checkOutput("slot1_old_phase", phase_inc, v1o);
    checkOutput("slot1_pend_kept", {44'h0, pend}, 48'hE);

    gotoCycle(t0 + 129);
    checkOutput("slot2_ch", {46'h0, ch_out}, 48'h2);
    checkOutput("slot2_phase", phase_inc, v2);
    checkOutput("slot2_pend", {44'h0, pend}, 48'hA);
    gotoCycle(t0 + 193);
    checkOutput("slot3_ch", {46'h0, ch_out}, 48'h3);
    checkOutput("slot3_phase", phase_inc, v3);
    checkOutput("slot3_pend", {44'h0, pend}, 48'h2);
    gotoCycle(t0 + 257);
    checkOutput("slot4_ch", {46'h0, ch_out}, 48'h0);
    checkOutput("slot4_phase", phase_inc, 48'h0);
    gotoCycle(t0 + 321);
    checkOutput("slot5_ch", {46'h0, ch_out}, 48'h1);
    checkOutput("slot5_new_phase", phase_inc, v1n);
    checkOutput("slot5_pend", {44'h0, pend}, 48'h0);
    gotoCycle(t0 + 385);
    checkOutput("slot6_phase", phase_inc, v2);
    gotoCycle(t0 + 449);
    checkOutput("slot7_ch", {46'h0, ch_out}, 48'h3);
    checkOutput("slot7_phase", phase_inc, v3);

    gotoCycle(t0 + 480);
    run = 1'b0;
    gotoCycle(t0 + 511);
    checkOutput("stop_last_busy", {47'h0, busy}, 48'h1);
    checkOutput("stop_last_valid", {47'h0, ch_valid}, 48'h1);
    gotoCycle(t0 + 512);
    checkOutput("stop_busy", {47'h0, busy}, 48'h0);
    checkOutput("stop_valid", {47'h0, ch_valid}, 48'h0);
    checkOutput("stop_phase_held", phase_inc, v3);
    gotoCycle(t0 + 530);
    checkOutput("idle_busy", {47'h0, busy}, 48'h0);
    checkOutput("idle_phase_held", phase_inc, v3);
    checkOutput("idle_ch", {46'h0, ch_out}, 48'h3);

    writeInc(2'd0, v0);
    run = 1'b1;
    t1 = cyc + 1;
    gotoCycle(t1 + 1);
    checkOutput("restart_ch", {46'h0, ch_out}, 48'h0);
    checkOutput("restart_phase", phase_inc, v0);
    checkOutput("restart_pend", {44'h0, pend}, 48'h0);
    gotoCycle(t1 + 2);
    applyStimulus(2'd2, 2'd2, 16'h5555);
    checkOutput("settle_commit_pend", {44'h0, pend}, 48'h4);
    gotoCycle(t1 + 4);
    run = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_phase", phase_inc, 48'h0);
    checkOutput("async_rst_ch", {46'h0, ch_out}, 48'h0);
    checkOutput("async_rst_pend", {44'h0, pend}, 48'h0);
    checkOutput("async_rst_busy", {47'h0, busy}, 48'h0);
    checkOutput("async_rst_valid", {47'h0, ch_valid}, 48'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run = 1'b1;
    t2 = cyc + 1;
    gotoCycle(t2);
    checkOutput("post_rst_busy", {47'h0, busy}, 48'h1);
    gotoCycle(t2 + 1);
    checkOutput("post_rst_ch", {46'h0, ch_out}, 48'h0);
    checkOutput("post_rst_phase", phase_inc, 48'h0);
    gotoCycle(t2 + 9);
    checkOutput("post_rst_valid", {47'h0, ch_valid}, 48'h1);
    gotoCycle(t2 + 65);
    checkOutput("post_rst_ch1", {46'h0, ch_out}, 48'h1);
    checkOutput("post_rst_ch1_phase", phase_inc, 48'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
